disp_sr_mc: RTL and testbench



---
 rtl/disp_pkg.sv | 38 +++
 rtl/util_pkg.sv | 20 ++
 rtl/delay.sv | 45 ++++
 rtl/disp_sr_mc.sv | 241 ++++++++++++++++++++++++
 tb/tb_disp_sr_mc.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : disp_pkg
//  Brief    : Types, constants and helpers for the display shift-register
//             driver.
//  Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam int LAT_CNT_W      = 4;
    localparam int CHAIN_MAX_BITS = 1024;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        SHIFT_LO   = 3'd2,
        SHIFT_HI   = 3'd3,
        LATCH      = 3'd4,
        LATCH_HOLD = 3'd5
    } disp_state_t;

    // Reverses the low nbits of a chain; bits at and above nbits return 0.
    function automatic logic [CHAIN_MAX_BITS-1:0] chain_reverse(
        input logic [CHAIN_MAX_BITS-1:0] chain,
        input int                        nbits
    );
        logic [CHAIN_MAX_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < CHAIN_MAX_BITS; i++) begin
            if (i < nbits) begin
                r[i] = chain[nbits-1-i];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/util_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : util_pkg
//  Brief    : Shared elaboration-time helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package util_pkg;

    // Ceiling log2 for sizing counters and indices; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay.sv
`default_nettype none
// ============================================================================
//  Module   : delay
//  Brief    : Fixed-latency register pipeline, cleared by asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module delay #(
    parameter int SIZE   = 1,
    parameter int CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] din,
    output logic [SIZE-1:0] dout
);

    logic [SIZE-1:0] r_stage [CYCLES];

    // First stage captures the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage[0] <= '0;
        end else begin
            r_stage[0] <= din;
        end
    end

    genvar i;
    generate
        for (i = 1; i < CYCLES; i++) begin : g_stage
            // Each further stage adds one clk of latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage[i] <= '0;
                end else begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end
    endgenerate

    assign dout = r_stage[CYCLES-1];

endmodule
`default_nettype wire

// File: rtl/disp_sr_mc.sv
`default_nettype none
// ============================================================================
//  Module   : disp_sr_mc
//  Brief    : Multi-channel display shift-register driver. Double-buffered
//             frame store, NCHAN serial chains sharing one sclk and latch,
//             paced by external tick / frame_start strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module disp_sr_mc
    import util_pkg::*;
    import disp_pkg::*;
#(
    parameter int NCHAN     = 1,
    parameter int NBITS     = 256,
    parameter int MSB_FIRST = 1,
    parameter int LAT_TICKS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   tick,
    input  logic [NCHAN*NBITS-1:0] data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   disp_sclk,
    output logic                   disp_lat,
    output logic [NCHAN-1:0]       disp_sin
);

    localparam int                   c_BIT_W    = clog2(NBITS);
    localparam int                   c_W        = NCHAN * NBITS;
    localparam logic [c_BIT_W-1:0]   c_LAST_BIT = c_BIT_W'(NBITS - 1);
    localparam logic [LAT_CNT_W-1:0] c_LAST_LAT = LAT_CNT_W'(LAT_TICKS - 1);

    disp_state_t            r_state;
    disp_state_t            w_state_next;

    logic [c_W-1:0]         r_shadow;
    logic [c_W-1:0]         r_active;
    logic [c_W-1:0]         r_shift;
    logic [c_W-1:0]         w_load_val;
    logic [c_W-1:0]         w_shifted;
    logic                   r_shadow_full;

    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [LAT_CNT_W-1:0]   r_lat_cnt;

    logic                   r_sclk;
    logic                   r_lat;
    logic [NCHAN-1:0]       r_sin;
    logic [NCHAN-1:0]       w_head;
    logic                   r_frame_done;
    logic                   r_overrun;
    logic [NCHAN+1:0]       w_out;

    logic                   w_xfer;
    logic                   w_promote;
    logic                   w_do_load;
    logic                   w_do_lo;
    logic                   w_do_hi;
    logic                   w_do_latch;
    logic                   w_do_hold;
    logic                   w_lat_end;
    logic                   w_last_bit;

    assign data_ready = !r_shadow_full;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign w_xfer     = data_valid && !r_shadow_full;
    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    // Per-chain views: head bit, one-step shift, and load image (reversed
    // when the chain is sent LSB first so the shifter always drains the MSB).
    genvar c;
    generate
        for (c = 0; c < NCHAN; c++) begin : g_chain
            assign w_head[c] = r_shift[c*NBITS + NBITS-1];
            assign w_shifted[c*NBITS +: NBITS] = {r_shift[c*NBITS +: NBITS-1], 1'b0};
            if (MSB_FIRST != 0) begin : g_msb
                assign w_load_val[c*NBITS +: NBITS] = r_active[c*NBITS +: NBITS];
            end else begin : g_lsb
                assign w_load_val[c*NBITS +: NBITS] =
                    NBITS'(chain_reverse(CHAIN_MAX_BITS'(r_active[c*NBITS +: NBITS]), NBITS));
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state action strobes.
    always_comb begin
        w_state_next = r_state;
        w_promote    = 1'b0;
        w_do_load    = 1'b0;
        w_do_lo      = 1'b0;
        w_do_hi      = 1'b0;
        w_do_latch   = 1'b0;
        w_do_hold    = 1'b0;
        w_lat_end    = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_promote    = r_shadow_full;
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_do_load    = 1'b1;
                w_state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (tick) begin
                    w_do_lo      = 1'b1;
                    w_state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    w_do_hi      = 1'b1;
                    w_state_next = w_last_bit ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (tick) begin
                    w_do_latch   = 1'b1;
                    w_state_next = LATCH_HOLD;
                end
            end
            LATCH_HOLD: begin
                if (tick) begin
                    w_do_hold = 1'b1;
                    if (r_lat_cnt == c_LAST_LAT) begin
                        w_lat_end    = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Frame store: promote shadow at frame start, then accept a new transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow      <= '0;
            r_active      <= '0;
            r_shadow_full <= 1'b0;
        end else begin
            if (w_promote) begin
                r_active      <= r_shadow;
                r_shadow_full <= 1'b0;
            end
            if (w_xfer) begin
                r_shadow      <= data_in;
                r_shadow_full <= 1'b1;
            end
        end
    end

    // Shift register and bit / latch-width counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (w_do_load) begin
                r_shift <= w_load_val;
            end else if (w_do_hi) begin
                r_shift <= w_shifted;
            end
            if (w_do_hi) begin
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            end
            if (w_do_latch) begin
                r_lat_cnt <= '0;
            end else if (w_do_hold) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
        end
    end

    // Internal pin levels plus the done / overrun pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk       <= 1'b0;
            r_lat        <= 1'b0;
            r_sin        <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_do_lo) begin
                r_sin  <= w_head;
                r_sclk <= 1'b0;
            end
            if (w_do_hi) begin
                r_sclk <= 1'b1;
            end
            if (w_do_latch) begin
                r_sclk <= 1'b0;
                r_lat  <= 1'b1;
                r_sin  <= '0;
            end
            if (w_lat_end) begin
                r_lat <= 1'b0;
            end
            r_frame_done <= w_lat_end;
            r_overrun    <= frame_start && (r_state != IDLE);
        end
    end

    // Pin stage: one flop between the internal levels and the display pins.
    delay #(
        .SIZE   (NCHAN + 2),
        .CYCLES (1)
    ) u_out_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({r_lat, r_sclk, r_sin}),
        .dout  (w_out)
    );

    assign disp_lat  = w_out[NCHAN+1];
    assign disp_sclk = w_out[NCHAN];
    assign disp_sin  = w_out[NCHAN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_disp_sr_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_sr_mc
//  Brief    : Self-checking bench for disp_sr_mc, NCHAN=2 NBITS=8; one
//             MSB-first and one LSB-first instance share all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_disp_sr_mc;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        tick;
    logic [15:0] data_in;
    logic        data_valid;

    logic        rdy_a, busy_a, done_a, ovr_a, sclk_a, lat_a;
    logic [1:0]  sin_a;
    logic        rdy_b, busy_b, done_b, ovr_b, sclk_b, lat_b;
    logic [1:0]  sin_b;

    int n_checks = 0;
    int n_pass   = 0;
    int tcnt     = 0;

    disp_sr_mc #(.NCHAN(2), .NBITS(8), .MSB_FIRST(1), .LAT_TICKS(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .tick(tick),
        .data_in(data_in), .data_valid(data_valid), .data_ready(rdy_a),
        .busy(busy_a), .frame_done(done_a), .overrun(ovr_a),
        .disp_sclk(sclk_a), .disp_lat(lat_a), .disp_sin(sin_a)
    );

    disp_sr_mc #(.NCHAN(2), .NBITS(8), .MSB_FIRST(0), .LAT_TICKS(1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .tick(tick),
        .data_in(data_in), .data_valid(data_valid), .data_ready(rdy_b),
        .busy(busy_b), .frame_done(done_b), .overrun(ovr_b),
        .disp_sclk(sclk_b), .disp_lat(lat_b), .disp_sin(sin_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clks, never on consecutive clks.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = tcnt + 1;
            tick = ((tcnt % 4) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Pin monitor: sclk rises, serial series, latch pulses, strobes.
    logic       prev_sclk_a = 1'b0, prev_sclk_b = 1'b0, prev_lat_a = 1'b0;
    logic [7:0] ser_a0 = '0, ser_a1 = '0, ser_b0 = '0, ser_b1 = '0;
    int rise_a = 0, rise_b = 0, lat_pulses = 0, lat_run = 0, last_lat_w = 0;
    int done_cnt = 0, ovr_cnt = 0, rdy_hi_cnt = 0, rdy_lo_cnt = 0;

    always @(negedge clk) begin
        prev_sclk_a <= sclk_a;
        prev_sclk_b <= sclk_b;
        prev_lat_a  <= lat_a;
        if (sclk_a && !prev_sclk_a) begin
            rise_a <= rise_a + 1;
            ser_a0 <= {ser_a0[6:0], sin_a[0]};
            ser_a1 <= {ser_a1[6:0], sin_a[1]};
        end
        if (sclk_b && !prev_sclk_b) begin
            rise_b <= rise_b + 1;
            ser_b0 <= {ser_b0[6:0], sin_b[0]};
            ser_b1 <= {ser_b1[6:0], sin_b[1]};
        end
        if (lat_a && !prev_lat_a) lat_pulses <= lat_pulses + 1;
        if (lat_a) lat_run <= lat_run + 1;
        if (!lat_a && prev_lat_a) begin
            last_lat_w <= lat_run;
            lat_run    <= 0;
        end
        if (done_a) done_cnt <= done_cnt + 1;
        if (ovr_a)  ovr_cnt  <= ovr_cnt + 1;
        if (rdy_a)  rdy_hi_cnt <= rdy_hi_cnt + 1;
        else        rdy_lo_cnt <= rdy_lo_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    task automatic load_data(input logic [15:0] d);
        data_in    = d;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_a) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic wait_rises(input string name, input int base, input int n);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (rise_a - base >= n) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, {31'd0, hit}, 32'd1);
    endtask

    typedef struct {
        logic        load;
        logic [15:0] data;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int s_ra, s_rb, s_lat, s_done, s_lo, s_hi, s_ovr;

        vecs[0] = '{1'b1, 16'h3CA5, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b1, 16'h8001, 8'h01, 8'h80, 8'h80, 8'h01};
        vecs[2] = '{1'b0, 16'h0000, 8'h01, 8'h80, 8'h80, 8'h01};
        vecs[3] = '{1'b1, 16'h0E96, 8'h96, 8'h0E, 8'h69, 8'h70};

        rst_n       = 1'b0;
        frame_start = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        check("rst_ready_a", {31'd0, rdy_a},  32'd1);
        check("rst_ready_b", {31'd0, rdy_b},  32'd1);
        check("rst_busy_a",  {31'd0, busy_a}, 32'd0);
        check("rst_busy_b",  {31'd0, busy_b}, 32'd0);
        check("rst_done",    {30'd0, done_a, done_b}, 32'd0);
        check("rst_overrun", {30'd0, ovr_a, ovr_b},   32'd0);
        check("rst_pins_a",  {28'd0, lat_a, sclk_a, sin_a}, 32'd0);
        check("rst_pins_b",  {28'd0, lat_b, sclk_b, sin_b}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].load) begin
                load_data(vecs[v].data);
                check($sformatf("v%0d_ready_low_after_load", v), {31'd0, rdy_a}, 32'd0);
            end
            s_ra = rise_a; s_rb = rise_b; s_lat = lat_pulses;
            s_done = done_cnt; s_lo = rdy_lo_cnt;
            pulse_start();
            check($sformatf("v%0d_busy_after_start", v), {31'd0, busy_a}, 32'd1);
            if (vecs[v].load) begin
                check($sformatf("v%0d_ready_after_promote", v), {31'd0, rdy_a}, 32'd1);
            end
            wait_done($sformatf("v%0d_frame_done_seen", v));
            check($sformatf("v%0d_rises_a", v), rise_a - s_ra, 32'd8);
            check($sformatf("v%0d_rises_b", v), rise_b - s_rb, 32'd8);
            check($sformatf("v%0d_ser_a0", v), {24'd0, ser_a0}, {24'd0, vecs[v].a0});
            check($sformatf("v%0d_ser_a1", v), {24'd0, ser_a1}, {24'd0, vecs[v].a1});
            check($sformatf("v%0d_ser_b0", v), {24'd0, ser_b0}, {24'd0, vecs[v].b0});
            check($sformatf("v%0d_ser_b1", v), {24'd0, ser_b1}, {24'd0, vecs[v].b1});
            check($sformatf("v%0d_lat_pulses", v), lat_pulses - s_lat, 32'd1);
            check($sformatf("v%0d_lat_width", v), last_lat_w, 32'd4);
            check($sformatf("v%0d_done_pulses", v), done_cnt - s_done, 32'd1);
            check($sformatf("v%0d_idle_after", v), {31'd0, busy_a}, 32'd0);
            if (!vecs[v].load) begin
                check($sformatf("v%0d_ready_stayed_high", v), rdy_lo_cnt - s_lo, 32'd0);
            end
        end

        // frame_start at bit 3 of a running frame
        s_ra = rise_a; s_ovr = ovr_cnt; s_lat = lat_pulses;
        pulse_start();
        wait_rises("ovr_reach_bit3", s_ra, 3);
        pulse_start();
        wait_done("ovr_frame_done_seen");
        check("ovr_pulses", ovr_cnt - s_ovr, 32'd1);
        check("ovr_rises", rise_a - s_ra, 32'd8);
        check("ovr_ser_a0", {24'd0, ser_a0}, 32'h96);
        check("ovr_ser_a1", {24'd0, ser_a1}, 32'h0E);
        check("ovr_lat_pulses", lat_pulses - s_lat, 32'd1);

        // handshake on the same clk as frame_start
        data_in     = 16'hFFFF;
        data_valid  = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        data_valid  = 1'b0;
        frame_start = 1'b0;
        check("hs_ready_low", {31'd0, rdy_a}, 32'd0);
        s_hi = rdy_hi_cnt;
        wait_done("hs_old_frame_done_seen");
        check("hs_old_ser_a0", {24'd0, ser_a0}, 32'h96);
        check("hs_old_ser_a1", {24'd0, ser_a1}, 32'h0E);
        check("hs_ready_held_low", rdy_hi_cnt - s_hi, 32'd0);
        pulse_start();
        check("hs_ready_back", {31'd0, rdy_a}, 32'd1);
        wait_done("hs_new_frame_done_seen");
        check("hs_new_ser_a0", {24'd0, ser_a0}, 32'hFF);
        check("hs_new_ser_a1", {24'd0, ser_a1}, 32'hFF);
        check("hs_new_ser_b0", {24'd0, ser_b0}, 32'hFF);

        // reset at bit 5 of a running frame
        s_ra = rise_a;
        pulse_start();
        wait_rises("rst_reach_bit5", s_ra, 5);
        s_lat = lat_pulses; s_done = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pins_a", {28'd0, lat_a, sclk_a, sin_a}, 32'd0);
        check("mid_rst_pins_b", {28'd0, lat_b, sclk_b, sin_b}, 32'd0);
        check("mid_rst_busy",  {30'd0, busy_a, busy_b}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("post_rst_no_latch", lat_pulses - s_lat, 32'd0);
        check("post_rst_no_done", done_cnt - s_done, 32'd0);
        check("post_rst_busy", {31'd0, busy_a}, 32'd0);
        check("post_rst_ready", {30'd0, rdy_a, rdy_b}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
